pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit.sv | 97 +++++++++
 tb/tb_pipe_hazard_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: per-register latency scoreboard, memory freeze,
// branch flush sequencing and stall statistics.
module pipe_hazard_unit #(
  parameter int AW          = 5,
  parameter int NRD         = 2,
  parameter int CW          = 3,
  parameter int ZREG        = 31,
  parameter int FLUSH_DEPTH = 2,
  parameter int SW          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [NRD*AW-1:0] id_rs,
  input  logic [NRD-1:0]    id_rs_used,
  input  logic              id_regwrite,
  input  logic [AW-1:0]     id_rd,
  input  logic [CW-1:0]     id_lat,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              ctrl_en,
  output logic              pipe_en,
  output logic              flush,
  output logic              issue,
  output logic [SW-1:0]     stall_cycles
);

  localparam int NR = 2 ** AW;
  localparam logic [AW-1:0] ZR = AW'(ZREG);

  logic [CW-1:0] sb [NR];
  logic [CW-1:0] fc;
  logic          flushing;
  logic          br;
  logic          hz;
  logic          raw_stall;
  logic          sb_load;

  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (id_rs_used[i] &&
          id_rs[i*AW +: AW] != ZR &&
          sb[id_rs[i*AW +: AW]] != '0)
        hz = 1'b1;
    end
    if (id_regwrite && id_rd != ZR && sb[id_rd] != '0)
      hz = 1'b1;
  end

  assign pipe_en   = ~(mem_req & ~mem_ready);
  assign flushing  = (fc != '0);
  assign br        = branch_taken & pipe_en;
  assign raw_stall = id_valid & hz & ~flushing & ~br;
  assign pc_en     = pipe_en & ~raw_stall;
  assign if_id_en  = pc_en;
  assign ctrl_en   = id_valid & ~raw_stall & ~flushing & ~br;
  assign issue     = ctrl_en & pipe_en;
  assign flush     = br | flushing;
  assign sb_load   = issue & id_regwrite & (id_rd != ZR);

  // a new branch restarts the flush window even mid-flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fc <= '0;
    else if (br)
      fc <= CW'(FLUSH_DEPTH - 1);
    else if (pipe_en && flushing)
      fc <= fc - CW'(1);
  end

  // the zero register is never loaded, so its entry stays 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NR; r++)
        sb[r] <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (sb_load && id_rd == AW'(r))
          sb[r] <= id_lat;
        else if (pipe_en && sb[r] != '0)
          sb[r] <= sb[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (!pc_en && stall_cycles != '1)
      stall_cycles <= stall_cycles + SW'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed table plus random traffic
// against a readiness-time reference model.
module tb_pipe_hazard_unit;

  localparam int ZREG = 31;
  localparam int FD   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [1:0]  id_rs_used = '0;
  logic        id_regwrite = 1'b0;
  logic [4:0]  id_rd = '0;
  logic [2:0]  id_lat = '0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;

  logic        pc_en, if_id_en, ctrl_en, pipe_en, flush, issue;
  logic [31:0] sc;
  logic        pc_en_b, if_id_en_b, ctrl_en_b, pipe_en_b, flush_b, issue_b;
  logic [3:0]  sc_b;

  pipe_hazard_unit u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_regwrite(id_regwrite), .id_rd(id_rd),
    .id_lat(id_lat), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_en(pc_en), .if_id_en(if_id_en),
    .ctrl_en(ctrl_en), .pipe_en(pipe_en), .flush(flush), .issue(issue),
    .stall_cycles(sc)
  );

  pipe_hazard_unit #(.SW(4)) u_dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_regwrite(id_regwrite), .id_rd(id_rd),
    .id_lat(id_lat), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
    .ctrl_en(ctrl_en_b), .pipe_en(pipe_en_b), .flush(flush_b),
    .issue(issue_b), .stall_cycles(sc_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic       rw;
    logic [4:0] rd;
    logic [2:0] lat;
    logic       mreq;
    logic       mrdy;
    logic       bt;
    logic [4:0] exp;
  } vec_t;

  int     total = 0;
  int     bad = 0;
  int     adv;
  int     flush_until;
  int     ready_at [32];
  longint cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int v, int rs0, int used, int rw, int rd,
                              int lat, int mreq, int mrdy, int bt, int exp);
    vec_t r;
    r.v = 1'(v); r.rs0 = 5'(rs0); r.rs1 = 5'd0; r.used = 2'(used);
    r.rw = 1'(rw); r.rd = 5'(rd); r.lat = 3'(lat);
    r.mreq = 1'(mreq); r.mrdy = 1'(mrdy); r.bt = 1'(bt);
    r.exp = 5'(exp);
    return r;
  endfunction

  // model: a register is busy until the advancing-edge count reaches ready_at
  function automatic logic busy(input logic [4:0] r);
    return (int'(r) != ZREG) && (adv < ready_at[r]);
  endfunction

  // returns {pc, if_id, ctrl, pipe, flush, issue}
  function automatic logic [5:0] model_out();
    logic pipe, br, fl, hz, raw, pc, ctrl;
    pipe = !(mem_req && !mem_ready);
    br   = branch_taken && pipe;
    fl   = adv < flush_until;
    hz   = 1'b0;
    for (int i = 0; i < 2; i++)
      if (id_rs_used[i] && busy(id_rs[i*5 +: 5])) hz = 1'b1;
    if (id_regwrite && busy(id_rd)) hz = 1'b1;
    raw  = id_valid && hz && !fl && !br;
    pc   = pipe && !raw;
    ctrl = id_valid && !raw && !fl && !br;
    return {pc, pc, ctrl, pipe, br || fl, ctrl && pipe};
  endfunction

  task automatic model_edge(input logic [5:0] e);
    if (!e[5]) cnt++;
    if (e[2]) begin
      if (e[0] && id_regwrite && int'(id_rd) != ZREG)
        ready_at[id_rd] = adv + 1 + int'(id_lat);
      if (branch_taken) flush_until = adv + FD;
      adv++;
    end
  endtask

  task automatic model_reset();
    adv = 0;
    flush_until = 0;
    cnt = 0;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
  endtask

  task automatic drive(input vec_t t);
    id_valid     = t.v;
    id_rs        = {t.rs1, t.rs0};
    id_rs_used   = t.used;
    id_regwrite  = t.rw;
    id_rd        = t.rd;
    id_lat       = t.lat;
    mem_req      = t.mreq;
    mem_ready    = t.mrdy;
    branch_taken = t.bt;
  endtask

  task automatic step(input vec_t t, input int idx, input bit use_tbl);
    logic [5:0] e;
    drive(t);
    @(negedge clk);
    e = model_out();
    chk($sformatf("out%0d", idx),
        64'({pc_en, if_id_en, ctrl_en, pipe_en, flush, issue}), 64'(e));
    chk($sformatf("out_b%0d", idx),
        64'({pc_en_b, if_id_en_b, ctrl_en_b, pipe_en_b, flush_b, issue_b}),
        64'(e));
    chk($sformatf("stall%0d", idx), 64'(sc), 64'(cnt));
    chk($sformatf("stall4_%0d", idx), 64'(sc_b), 64'(cnt > 15 ? 15 : cnt));
    if (use_tbl)
      chk($sformatf("row%0d", idx),
          64'({pc_en, ctrl_en, pipe_en, flush, issue}), 64'(t.exp));
    model_edge(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 3))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  vec_t tbl [23];
  vec_t rv;

  initial begin
    // {pc, ctrl, pipe, flush, issue}
    tbl[0]  = mk(1, 0,  0, 1, 5,  1, 0, 0, 0, 'b11101);
    tbl[1]  = mk(1, 5,  1, 0, 0,  0, 0, 0, 0, 'b00100);
    tbl[2]  = mk(1, 5,  1, 0, 0,  0, 0, 0, 0, 'b11101);
    tbl[3]  = mk(1, 0,  0, 1, 31, 3, 0, 0, 0, 'b11101);
    tbl[4]  = mk(1, 31, 1, 0, 0,  0, 0, 0, 0, 'b11101);
    tbl[5]  = mk(1, 0,  0, 1, 7,  2, 0, 0, 0, 'b11101);
    tbl[6]  = mk(0, 0,  0, 0, 0,  0, 1, 0, 0, 'b00000);
    tbl[7]  = mk(0, 0,  0, 0, 0,  0, 1, 0, 0, 'b00000);
    tbl[8]  = mk(0, 0,  0, 0, 0,  0, 1, 0, 0, 'b00000);
    tbl[9]  = mk(0, 0,  0, 0, 0,  0, 1, 0, 0, 'b00000);
    tbl[10] = mk(1, 7,  1, 0, 0,  0, 0, 0, 0, 'b00100);
    tbl[11] = mk(1, 7,  1, 0, 0,  0, 0, 0, 0, 'b00100);
    tbl[12] = mk(1, 7,  1, 0, 0,  0, 0, 0, 0, 'b11101);
    tbl[13] = mk(1, 0,  0, 1, 9,  3, 0, 0, 0, 'b11101);
    tbl[14] = mk(1, 9,  1, 0, 0,  0, 0, 0, 1, 'b10110);
    tbl[15] = mk(1, 9,  1, 0, 0,  0, 0, 0, 0, 'b10110);
    tbl[16] = mk(1, 9,  1, 0, 0,  0, 0, 0, 0, 'b00100);
    tbl[17] = mk(0, 0,  0, 0, 0,  0, 0, 0, 1, 'b10110);
    tbl[18] = mk(0, 0,  0, 0, 0,  0, 0, 0, 1, 'b10110);
    tbl[19] = mk(0, 0,  0, 0, 0,  0, 0, 0, 0, 'b10110);
    tbl[20] = mk(0, 0,  0, 0, 0,  0, 0, 0, 0, 'b10100);
    tbl[21] = mk(0, 0,  0, 0, 0,  0, 1, 0, 1, 'b00000);
    tbl[22] = mk(0, 0,  0, 0, 0,  0, 0, 0, 0, 'b10100);

    model_reset();
    #2;
    chk("rst_idle", 64'({pc_en, if_id_en, ctrl_en, pipe_en, flush, issue}),
        64'(6'b110100));
    chk("rst_sc", 64'(sc), 64'd0);
    id_valid = 1'b1;
    #1;
    chk("rst_valid", 64'({pc_en, if_id_en, ctrl_en, pipe_en, flush, issue}),
        64'(6'b111101));
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 23; i++) step(tbl[i], i, 1'b1);
    chk("stall_total", 64'(sc), 64'd9);

    // reset dropped in the first flush cycle
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 100, 1'b0);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("flush_pre", 64'(flush), 64'd1);
    reset = 1'b0;
    #1;
    chk("flush_rst", 64'(flush), 64'd0);
    chk("sc_rst", 64'(sc), 64'd0);
    chk("ctrl_rst", 64'({pc_en, ctrl_en, issue}), 64'(3'b111));
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 101, 1'b0);

    for (int i = 0; i < 20; i++)
      step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 200 + i, 1'b0);
    chk("sat4", 64'(sc_b), 64'd15);
    chk("sat32", 64'(sc), 64'd20);

    for (int i = 0; i < 400; i++) begin
      rv.v    = 1'($urandom_range(0, 1));
      rv.rs0  = pick();
      rv.rs1  = pick();
      rv.used = 2'($urandom_range(0, 3));
      rv.rw   = 1'($urandom_range(0, 1));
      rv.rd   = pick();
      rv.lat  = 3'($urandom_range(0, 7));
      rv.mreq = ($urandom_range(0, 4) == 0);
      rv.mrdy = 1'($urandom_range(0, 1));
      rv.bt   = ($urandom_range(0, 11) == 0);
      rv.exp  = '0;
      step(rv, 1000 + i, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
